unidade_de_busca: RTL
=====================

# unidade_de_busca

Instruction fetch stage that feeds the control unit. It reads one instruction byte per step from instruction memory at the program counter and splits it into `opcode` (bits 7:4) and `operando` (bits 3:0). It presents the pair to the control unit with a valid/ready handshake, then advances the PC. It also detects the halt opcode, and optionally executes unconditional jumps locally.

## Interface
- `LARG_PC`, default 4: program counter and instruction address width.
- `LAT_MEM`, default 1: instruction memory read latency in cycles, counted from the `rdInstr` cycle; legal range 1–7.
- `clock` input, 1 bit: single clock; all state changes on the rising edge.
- `resetn` input, 1 bit: reset, asynchronous and active-low.
- `habilita` input, 1 bit: run enable; sampled only in state BUSCA.
- `endInstr` output, `LARG_PC` bits: instruction memory address; always equals `pc`.
- `rdInstr` output, 1 bit: instruction memory read strobe.
- `instrByte` input, 8 bits: instruction memory read data.
- `opcode` output, 4 bits: decoded `instrByte[7:4]`.
- `operando` output, 4 bits: decoded `instrByte[3:0]`.
- `instrValida` output, 1 bit: `opcode` and `operando` hold a valid instruction.
- `ucPronta` input, 1 bit: control unit accepts the instruction.
- `pc` output, `LARG_PC` bits: current program counter.
- `parado` output, 1 bit: halted.

## Operation
- The FSM has four states: BUSCA, ESPERA, ENTREGA and PARADO. A 3-bit counter `cont` tracks memory latency.
- **BUSCA:**
  - If `habilita`=1: `rdInstr`=1, load `cont`=`LAT_MEM`, go to ESPERA.
  - If `habilita`=0: `rdInstr`=0, stay in BUSCA.
- **ESPERA:**
  - `rdInstr`=0 and `cont` decrements each cycle.
  - At the edge where `cont`==1, sample `instrByte` into `opcode`/`operando` and decode it:
    - 4'b1111 (halt): go to PARADO. `instrValida` is never asserted for halt.
    - 4'b1110 with `SALTO_EN` defined: `pc` <= `operando`, zero-extended or truncated to `LARG_PC`. Go to BUSCA without delivering.
    - Any other opcode: go to ENTREGA.
- **ENTREGA:**
  - `instrValida`=1; `opcode`/`operando` stay stable.
  - On an edge with `ucPronta`=1: transfer completes, `pc` <= `pc`+1 (wraps modulo 2^`LARG_PC`), `instrValida` drops, go to BUSCA.
  - `ucPronta`=0: hold indefinitely.
- **PARADO:**
  - `parado`=1 and `rdInstr`=0; `pc` still points at the halt instruction.
  - Only `resetn` leaves this state.
- `habilita` falling outside BUSCA does not abort a fetch; the step in progress completes.
- `ucPronta` is ignored outside ENTREGA.
- Reset values:
  - `pc`=0 and `endInstr`=0.
  - `opcode`=0 and `operando`=0.
  - `rdInstr`=0, `instrValida`=0, `parado`=0.
  - State BUSCA, `cont`=0.
- Reset mid-operation (any state) takes effect immediately, with no clock edge needed. Any captured or in-flight instruction is discarded.

## Timing
- Cycle-level sequence, with the BUSCA cycle as c0:
  - c0: BUSCA, `rdInstr`=1.
  - c1 through c`LAT_MEM`: ESPERA.
  - The byte is captured at the end of c`LAT_MEM`.
  - From c`LAT_MEM`+1: `instrValida`=1.
- Fetch-to-valid latency is `LAT_MEM`+1 cycles.
- With immediate `ucPronta`, throughput is one instruction per `LAT_MEM`+2 cycles.
- Taken jump: next BUSCA at c`LAT_MEM`+1 with the new `pc`.
- Halt: `parado`=1 from c`LAT_MEM`+1.
- `pc` wrap: `pc`=2^`LARG_PC`−1 accepted → `pc`=0.
- All outputs are registered except `endInstr` (wire equal to `pc`) and `rdInstr` (decoded from state and `habilita`).

## Configuration
- `SALTO_EN` defined: opcode 4'b1110 is a local jump. `pc` <= `operando`, the instruction is not delivered, and the control unit never sees it.
- `SALTO_EN` undefined: 4'b1110 is an ordinary instruction, delivered in ENTREGA, with `pc` incremented on acceptance.

## Test plan
- **Reset values:** reset asserted → all outputs at their reset values in the same cycle, with no clock edge. Then release with `habilita`=1 and memory[0]=8'hC5, `ucPronta`=1 → `rdInstr` pulse at `endInstr`=0; two cycles later `opcode`=4'hC, `operando`=4'h5, `instrValida`=1; next edge `pc`=1.
- **Backpressure:** hold `ucPronta`=0 for 5 cycles in ENTREGA → `instrValida` and the decoded pair are stable and `pc` is unchanged; raise `ucPronta` → one transfer, `pc`+1.
- **Halt:** memory[3]=8'hF0 → `parado`=1, `instrValida` never high for it, `pc`=3, no further `rdInstr` until reset.
- **Jump with `SALTO_EN`:** memory[2]=8'hE9 → next `endInstr`=9, 8'hE9 never delivered. Without `SALTO_EN` → delivered as `opcode`=4'hE, then `pc`=3.
- **Wrap and enable:** with `LAT_MEM`=3, `pc`=15 accepted → `pc`=0 and valid appears 4 cycles after `rdInstr`. Hold `habilita`=0 in BUSCA → `rdInstr` stays 0. Assert `resetn`=0 during ESPERA → immediate return to the reset values.

Source files
------------

// File: rtl/unidade_de_busca_if.sv
// Fetch-to-control-unit bus: instruction memory port plus decoded instruction handshake.
// master = fetch stage, slave = memory/control-unit side.
interface unidade_de_busca_if #(
  parameter int LARG_PC = 4
);
  logic [LARG_PC-1:0] endInstr;
  logic               rdInstr;
  logic [7:0]         instrByte;
  logic [3:0]         opcode;
  logic [3:0]         operando;
  logic               instrValida;
  logic               ucPronta;

  modport master (
    output endInstr, rdInstr, opcode, operando, instrValida,
    input  instrByte, ucPronta
  );

  modport slave (
    input  endInstr, rdInstr, opcode, operando, instrValida,
    output instrByte, ucPronta
  );
endinterface

// File: rtl/unidade_de_busca.sv
// Instruction fetch stage: reads one byte per step, splits it into opcode/operando, hands it
// to the control unit with valid/ready, detects halt. Define SALTO_EN to execute 4'hE jumps locally.
//
// state   | meaning
// BUSCA   | idle / issue read strobe when habilita=1
// ESPERA  | waiting LAT_MEM cycles for memory data
// ENTREGA | instruction valid, waiting for ucPronta
// PARADO  | halt opcode seen, only reset leaves
module unidade_de_busca #(
  parameter int LARG_PC = 4,
  parameter int LAT_MEM = 1
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               habilita,
  unidade_de_busca_if.master bus,
  output logic [LARG_PC-1:0] pc,
  output logic               parado
);

  typedef enum logic [1:0] {
    BUSCA   = 2'd0,
    ESPERA  = 2'd1,
    ENTREGA = 2'd2,
    PARADO  = 2'd3
  } estado_t;

  localparam logic [3:0] OP_HALT  = 4'hF;
  localparam logic [3:0] OP_SALTO = 4'hE;

  estado_t            estado_q;
  logic [2:0]         cont_q;
  logic [LARG_PC-1:0] pc_q;
  logic [3:0]         opcode_q;
  logic [3:0]         operando_q;
  logic               valida_q;
  logic               parado_q;

  logic [3:0] op_mem;
  logic [3:0] arg_mem;

  assign op_mem  = bus.instrByte[7:4];
  assign arg_mem = bus.instrByte[3:0];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      estado_q   <= BUSCA;
      cont_q     <= 3'd0;
      pc_q       <= '0;
      opcode_q   <= 4'd0;
      operando_q <= 4'd0;
      valida_q   <= 1'b0;
      parado_q   <= 1'b0;
    end else begin
      case (estado_q)
        BUSCA: begin
          if (habilita) begin
            cont_q   <= 3'(LAT_MEM);
            estado_q <= ESPERA;
          end
        end

        ESPERA: begin
          cont_q <= cont_q - 3'd1;
          if (cont_q == 3'd1) begin
            opcode_q   <= op_mem;
            operando_q <= arg_mem;
            if (op_mem == OP_HALT) begin
              parado_q <= 1'b1;
              estado_q <= PARADO;
            end
`ifdef SALTO_EN
            else if (op_mem == OP_SALTO) begin
              // taken jump is never shown to the control unit
              pc_q     <= LARG_PC'(arg_mem);
              estado_q <= BUSCA;
            end
`endif
            else begin
              valida_q <= 1'b1;
              estado_q <= ENTREGA;
            end
          end
        end

        ENTREGA: begin
          if (bus.ucPronta) begin
            valida_q <= 1'b0;
            pc_q     <= pc_q + LARG_PC'(1);
            estado_q <= BUSCA;
          end
        end

        PARADO: begin
          estado_q <= PARADO;
        end

        default: estado_q <= BUSCA;
      endcase
    end
  end

  // strobe is gated by resetn so it reads 0 while reset is held
  assign bus.rdInstr     = resetn && (estado_q == BUSCA) && habilita;
  assign bus.endInstr    = pc_q;
  assign bus.opcode      = opcode_q;
  assign bus.operando    = operando_q;
  assign bus.instrValida = valida_q;
  assign pc              = pc_q;
  assign parado          = parado_q;

endmodule
